// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state codes, control bundle and decode helpers for the pipeline stall controller.
// The datapath and the bench decode `state` with these codes.
package pipeline_stall_controller_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_RESET      = 3'd0;
    localparam logic [STATE_W-1:0] S_RUN        = 3'd1;
    localparam logic [STATE_W-1:0] S_LOAD_STALL = 3'd2;
    localparam logic [STATE_W-1:0] S_BR_FLUSH   = 3'd3;
    localparam logic [STATE_W-1:0] S_MEM_WAIT   = 3'd4;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_hold;
    } ctrl_t;

    // Moore decode; illegal codes drive everything low until the FSM recovers.
    function automatic ctrl_t decode_ctrl(input logic [STATE_W-1:0] s);
        ctrl_t c;
        c = '0;
        case (s)
            S_RUN: begin
                c.pc_write   = 1'b1;
                c.ifid_write = 1'b1;
            end
            S_LOAD_STALL: begin
                c.idex_bubble = 1'b1;
            end
            S_BR_FLUSH: begin
                c.pc_write    = 1'b1;
                c.ifid_write  = 1'b1;
                c.ifid_flush  = 1'b1;
                c.idex_bubble = 1'b1;
            end
            S_MEM_WAIT: begin
                c.exmem_hold = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Memory stall outranks a taken branch, which outranks a load-use hazard.
    function automatic logic [STATE_W-1:0] run_next(input logic mem_busy,
                                                    input logic branch_taken,
                                                    input logic hazard);
        logic [STATE_W-1:0] n;
        if (mem_busy)          n = S_MEM_WAIT;
        else if (branch_taken) n = S_BR_FLUSH;
        else if (hazard)       n = S_LOAD_STALL;
        else                   n = S_RUN;
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Sequences PC / IF/ID / ID/EX / EX/MEM enables from hazard, branch and memory-busy inputs,
// with a saturating stall-cycle counter and a sticky memory-timeout flag.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               hazard,
    input  logic               branch_taken,
    input  logic               mem_busy,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               exmem_hold,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   stall_count,
    output logic               mem_timeout
);

    localparam int                WAIT_W    = $clog2(MAX_MEM_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_MEM_WAIT - 1);

    logic [STATE_W-1:0] state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_next;
    logic               timeout_set;
    logic               stall_inc;
    ctrl_t              ctrl;

    always_comb begin
        state_next  = S_RUN;
        wait_next   = wait_cnt;
        timeout_set = 1'b0;
        ctrl        = decode_ctrl(state);

        case (state)
            S_RESET: state_next = S_RUN;
            S_RUN, S_LOAD_STALL, S_BR_FLUSH:
                state_next = run_next(mem_busy, branch_taken, hazard);
            // On exit, branch/hazard are dropped; the hazard unit re-asserts them.
            S_MEM_WAIT: begin
                if (!mem_busy) begin
                    state_next = S_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next  = S_RUN;
                    timeout_set = 1'b1;
                end else begin
                    state_next = S_MEM_WAIT;
                end
            end
            default: state_next = S_RUN;
        endcase

        // Count only while staying, so wait_cnt never exceeds WAIT_LAST.
        if (state_next == S_MEM_WAIT) begin
            if (state != S_MEM_WAIT) wait_next = '0;
            else                     wait_next = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_RESET;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (timeout_set) mem_timeout <= 1'b1;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign exmem_hold  = ctrl.exmem_hold;

    assign stall_inc = (state == S_LOAD_STALL) || (state == S_MEM_WAIT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; CNT_W=4 so saturation is reachable quickly.
module tb_pipeline_stall_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       hazard, branch_taken, mem_busy;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
    logic [2:0] state;
    logic [3:0] stall_count;
    logic       mem_timeout;

    int vectors = 0;
    int miscompares = 0;

    // {state, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}
    localparam logic [7:0] O_RESET = 8'b000_00000;
    localparam logic [7:0] O_RUN   = 8'b001_11000;
    localparam logic [7:0] O_LS    = 8'b010_00010;
    localparam logic [7:0] O_BR    = 8'b011_11110;
    localparam logic [7:0] O_MW    = 8'b100_00001;

    pipeline_stall_controller #(.MAX_MEM_WAIT(15), .CNT_W(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .exmem_hold   (exmem_hold),
        .state        (state),
        .stall_count  (stall_count),
        .mem_timeout  (mem_timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] obs();
        return {state, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called 1 time unit after an edge; releases reset before the next edge, then steps into RUN.
    task automatic apply_reset();
        hazard = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hazard = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        tick(); tick();
        vectors++;
        if (obs() !== O_RESET) begin
            miscompares++; $display("FAIL reset_outputs: got %b want %b", obs(), O_RESET);
        end
        vectors++;
        if (stall_count !== 4'd0 || mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_counters: got cnt=%0d to=%b want cnt=0 to=0", stall_count, mem_timeout);
        end
        reset_n = 1'b1;
        #2;
        vectors++;
        if (obs() !== O_RESET) begin
            miscompares++; $display("FAIL dead_cycle: got %b want %b", obs(), O_RESET);
        end
        tick();
        vectors++;
        if (obs() !== O_RUN || stall_count !== 4'd0) begin
            miscompares++;
            $display("FAIL first_run: got %b cnt=%0d want %b cnt=0", obs(), stall_count, O_RUN);
        end
        tick();
        vectors++;
        if (obs() !== O_RUN) begin
            miscompares++; $display("FAIL run_steady: got %b want %b", obs(), O_RUN);
        end
    endtask

    task automatic test_load_stall();
        hazard = 1'b1;
        tick();
        hazard = 1'b0;
        vectors++;
        if (obs() !== O_LS) begin
            miscompares++; $display("FAIL load_stall: got %b want %b", obs(), O_LS);
        end
        tick();
        vectors++;
        if (obs() !== O_RUN || stall_count !== 4'd1) begin
            miscompares++;
            $display("FAIL load_stall_exit: got %b cnt=%0d want %b cnt=1", obs(), stall_count, O_RUN);
        end
    endtask

    task automatic test_branch_priority();
        hazard = 1'b1; branch_taken = 1'b1;
        tick();
        hazard = 1'b0; branch_taken = 1'b0;
        vectors++;
        if (obs() !== O_BR) begin
            miscompares++; $display("FAIL br_flush: got %b want %b", obs(), O_BR);
        end
        tick();
        vectors++;
        if (obs() !== O_RUN || stall_count !== 4'd1) begin
            miscompares++;
            $display("FAIL br_flush_exit: got %b cnt=%0d want %b cnt=1", obs(), stall_count, O_RUN);
        end
    endtask

    task automatic test_mem_wait();
        mem_busy = 1'b1; hazard = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (obs() !== O_MW) begin
                miscompares++; $display("FAIL mem_wait_%0d: got %b want %b", i, obs(), O_MW);
            end
        end
        // hazard still high on the exit edge must be ignored
        mem_busy = 1'b0;
        tick();
        hazard = 1'b0;
        vectors++;
        if (obs() !== O_RUN || stall_count !== 4'd5 || mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_wait_exit: got %b cnt=%0d to=%b want %b cnt=5 to=0",
                     obs(), stall_count, mem_timeout, O_RUN);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_busy = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++;
            if (obs() !== O_MW || mem_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_wait_%0d: got %b to=%b want %b to=0", i, obs(), mem_timeout, O_MW);
            end
        end
        tick();
        vectors++;
        if (obs() !== O_RUN || mem_timeout !== 1'b1 || stall_count !== 4'd15) begin
            miscompares++;
            $display("FAIL timeout_exit: got %b to=%b cnt=%0d want %b to=1 cnt=15",
                     obs(), mem_timeout, stall_count, O_RUN);
        end
        // second residency must also last the full 15 cycles (wait_cnt cleared on entry)
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++;
            if (obs() !== O_MW || mem_timeout !== 1'b1) begin
                miscompares++;
                $display("FAIL reenter_wait_%0d: got %b to=%b want %b to=1", i, obs(), mem_timeout, O_MW);
            end
        end
        tick();
        mem_busy = 1'b0; branch_taken = 1'b0;
        vectors++;
        if (obs() !== O_RUN || stall_count !== 4'd15) begin
            miscompares++;
            $display("FAIL reenter_exit: got %b cnt=%0d want %b cnt=15", obs(), stall_count, O_RUN);
        end
        tick();
        vectors++;
        if (obs() !== O_RUN || mem_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: got %b to=%b want %b to=1", obs(), mem_timeout, O_RUN);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        apply_reset();
        hazard = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_cnt = (i - 1 > 15) ? 4'd15 : 4'(i - 1);
            vectors++;
            if (obs() !== O_LS || stall_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL sat_%0d: got %b cnt=%0d want %b cnt=%0d", i, obs(), stall_count, O_LS, exp_cnt);
            end
        end
        hazard = 1'b0;
        tick();
        vectors++;
        if (obs() !== O_RUN || stall_count !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_hold: got %b cnt=%0d want %b cnt=15", obs(), stall_count, O_RUN);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        vectors++;
        if (obs() !== O_MW || mem_timeout !== 1'b1 || stall_count !== 4'd15) begin
            miscompares++;
            $display("FAIL pre_reset: got %b to=%b cnt=%0d want %b to=1 cnt=15",
                     obs(), mem_timeout, stall_count, O_MW);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== O_RESET || stall_count !== 4'd0 || mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b cnt=%0d to=%b want %b cnt=0 to=0",
                     obs(), stall_count, mem_timeout, O_RESET);
        end
        mem_busy = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        vectors++;
        if (obs() !== O_RUN || stall_count !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset_run: got %b cnt=%0d want %b cnt=0", obs(), stall_count, O_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_stall();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
